// File: rtl/bcd_to_binary_seq.sv
// Iterative BCD-to-binary converter: reverse double dabble, one shift per cycle.
// Optional digit-range check on accept enabled by BCD2BIN_CHECK_EN.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binary,
  output logic                  err
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BIN_W-1:0] binary_q, binary_d;
  logic [SR_W-1:0]  sr_fix;

  // Corrections apply to every digit of the already-shifted value in parallel.
  function automatic logic [SR_W-1:0] fix_digits(
    input logic [SR_W-1:0] v
  );
    logic [SR_W-1:0] r;
    r = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[BIN_W+4*d +: 4] >= 4'd8)
        r[BIN_W+4*d +: 4] = v[BIN_W+4*d +: 4] - 4'd3;
    end
    return r;
  endfunction

`ifdef BCD2BIN_CHECK_EN
  logic err_pend_q, err_pend_d;
  logic err_q, err_d;
  logic bad_in;

  function automatic logic any_bad(
    input logic [4*DIGITS-1:0] b
  );
    logic r;
    r = 1'b0;
    for (int d = 0; d < DIGITS; d++)
      r = r | (b[4*d +: 4] > 4'd9);
    return r;
  endfunction

  assign bad_in = any_bad(bcd_in);
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

  assign sr_fix = fix_digits(sr_q >> 1);

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    binary_d = binary_q;
`ifdef BCD2BIN_CHECK_EN
    err_pend_d = err_pend_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sr_d    = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = CNT_W'(BIN_W);
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef BCD2BIN_CHECK_EN
          err_pend_d = bad_in;
`endif
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sr_d  = sr_fix;
        cnt_d = cnt_q - CNT_W'(1);
        // cnt_q==0 cannot occur legally; treat it as last shift so we never hang
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          binary_d = sr_fix[BIN_W-1:0];
          state_d  = DONE;
`ifdef BCD2BIN_CHECK_EN
          err_d = err_pend_q;
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      binary_q <= '0;
`ifdef BCD2BIN_CHECK_EN
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      binary_q <= binary_d;
`ifdef BCD2BIN_CHECK_EN
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = binary_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized + directed bench for bcd_to_binary_seq.
// Reference model: decimal weighting of digits and a digit-range check.
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic                clock;
  logic                reset;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic                busy;
  logic                done;
  logic [BIN_W-1:0]    binary;
  logic                err;

  int n_chk;
  int n_err;

  bcd_to_binary_seq #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bcd_in(bcd_in),
    .busy  (busy),
    .done  (done),
    .binary(binary),
    .err   (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int bcd_val(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic bcd_bad(input logic [11:0] b);
    return (b[11:8] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  function automatic logic exp_err(input logic [11:0] b);
`ifdef BCD2BIN_CHECK_EN
    return bcd_bad(b);
`else
    return 1'b0 & bcd_bad(b);
`endif
  endfunction

  // Waits for done after an accept edge; checks latency and busy length.
  task automatic wait_done(input logic [11:0] b, input string tag);
    int lat;
    int nb;
    lat = 0;
    nb  = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, BIN_W);
    chk({tag, "_busy"}, nb, BIN_W);
    if (!bcd_bad(b))
      chk({tag, "_bin"}, binary, bcd_val(b));
    chk({tag, "_err"}, err, exp_err(b));
  endtask

  task automatic conv(input logic [11:0] b, input string tag);
    bcd_in = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bcd_in = 12'($urandom);
    wait_done(b, tag);
  endtask

  initial begin
    logic [11:0] b;
    int ndone;
    n_chk  = 0;
    n_err  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    tick();
    start  = 1'b1;
    bcd_in = 12'h555;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin", binary, 0);
    chk("rst_err", err, 0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    conv(12'h255, "t255");
    tick();
    chk("t255_pulse", done, 0);
    chk("t255_hold", binary, 255);
    conv(12'h999, "t999");
    conv(12'h000, "t000");
    conv(12'h100, "t100");

    // start while busy is dropped
    bcd_in = 12'h042;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    bcd_in = 12'h777;
    start  = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    repeat (30) begin
      if (done) ndone++;
      tick();
    end
    chk("busy_ign_ndone", ndone, 1);
    chk("busy_ign_bin", binary, 42);

    // back-to-back: second start in the DONE cycle
    conv(12'h123, "b2b1");
    bcd_in = 12'h456;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_hold", binary, 123);
    chk("b2b_busy", busy, 1);
    wait_done(12'h456, "b2b2");

    // reset during the fifth shift cycle
    bcd_in = 12'h321;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bin", binary, 0);
    ndone = 0;
    repeat (20) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_ndone", ndone, 0);

    conv(12'h1A3, "bad1A3");
    tick();
    chk("bad_idle_busy", busy, 0);
    chk("bad_idle_done", done, 0);
    conv(12'h245, "after_bad");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        b = 12'($urandom);
      else
        b = {4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9))};
      conv(b, "rnd");
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
